mem_ctrl: RTL

Main-memory responder for line-wide write and read requests. It sits at the memory end of the store-buffer drain port and the data-cache fill port. It arbitrates between the two ports and completes each request with a one-cycle acknowledge after a fixed latency. A backing array of memory lines holds the data, and the block is the single point of memory ordering for the processor.

---
 rtl/mem_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: main-memory responder for the store-buffer drain port (write)
// and the data-cache fill port (read).
//
// It grants one port at a time. With both ports requesting it alternates
// between them. It waits MEM_LATENCY cycles and then pulses the granted
// port's ack for one cycle. All ordering is enforced here: a write commits
// to the backing array before any later grant can read it.
//
// Ports
//   clk       system clock, all state changes on posedge
//   rst       synchronous active-high reset; clears every array line
//   wMemReq   write request, held until wMemAck
//   wAddrMem  write byte address (line index taken from the middle bits)
//   wDataMem  write line data, sampled in the ACK cycle
//   wMemAck   one-cycle write-committed pulse
//   rMemReq   read request, held until rMemAck
//   rAddrMem  read byte address
//   rDataMem  read line data, meaningful only while rMemAck is high
//   rMemAck   one-cycle read-data-valid pulse
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; arbitrate and grant on this edge if requested
// WAIT  | latency countdown; drop back to IDLE if the granted req falls
// ACK   | ack pulse to the granted port; write commits at end of cycle

module mem_ctrl #(
    parameter int MEM_LINES        = 256,
    parameter int MEM_IDX_BITS     = 8,
    parameter int LINE_OFFSET_BITS = 4,
    parameter int MEM_LATENCY      = 4,
    parameter int ARCH_BITS        = 32,
    parameter int MEMORY_LINE_BITS = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wMemReq,
    input  logic [ARCH_BITS-1:0]        wAddrMem,
    input  logic [MEMORY_LINE_BITS-1:0] wDataMem,
    output logic                        wMemAck,
    input  logic                        rMemReq,
    input  logic [ARCH_BITS-1:0]        rAddrMem,
    output logic [MEMORY_LINE_BITS-1:0] rDataMem,
    output logic                        rMemAck
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);
    localparam int         IDX_LSB  = LINE_OFFSET_BITS;
    localparam int         IDX_MSB  = LINE_OFFSET_BITS + MEM_IDX_BITS;

    state_t                      state, stateNext;
    logic [3:0]                  cnt, cntNext;
    logic                        grantWrite, grantWriteNext;
    // Direction of the most recent grant; 0 means read went last.
    logic                        lastGrantWrite, lastGrantWriteNext;
    logic [MEM_IDX_BITS-1:0]     idx, idxNext;
    logic                        memWrite;
    logic                        readLoad;

    logic [MEMORY_LINE_BITS-1:0] mem [MEM_LINES];

    logic [MEM_IDX_BITS-1:0]     wIdx;
    logic [MEM_IDX_BITS-1:0]     rIdx;
    logic                        pickWrite;
    logic                        grantedReq;

    // Offset bits and bits above the index are deliberately ignored, so
    // addresses alias modulo MEM_LINES lines.
    assign wIdx = wAddrMem[IDX_LSB +: MEM_IDX_BITS];
    assign rIdx = rAddrMem[IDX_LSB +: MEM_IDX_BITS];

    logic unusedAddrBits;
    assign unusedAddrBits = ^{wAddrMem[IDX_LSB-1:0], wAddrMem[ARCH_BITS-1:IDX_MSB],
                              rAddrMem[IDX_LSB-1:0], rAddrMem[ARCH_BITS-1:IDX_MSB]};

    // Round-robin: on a tie the port that did not win last time wins now.
    assign pickWrite  = wMemReq && (!rMemReq || !lastGrantWrite);
    assign grantedReq = grantWrite ? wMemReq : rMemReq;

    always_comb begin
        stateNext          = state;
        cntNext            = cnt;
        grantWriteNext     = grantWrite;
        lastGrantWriteNext = lastGrantWrite;
        idxNext            = idx;
        wMemAck            = 1'b0;
        rMemAck            = 1'b0;
        memWrite           = 1'b0;
        readLoad           = 1'b0;

        case (state)
            IDLE: begin
                if (wMemReq || rMemReq) begin
                    grantWriteNext     = pickWrite;
                    lastGrantWriteNext = pickWrite;
                    idxNext            = pickWrite ? wIdx : rIdx;
                    cntNext            = CNT_LOAD;
                    stateNext          = WAIT;
                end
            end
            WAIT: begin
                // The abort check comes first, so a store-buffer clear on the
                // last wait cycle still suppresses the ack and the write.
                if (!grantedReq) begin
                    stateNext = IDLE;
                end else if (cnt == 4'd0) begin
                    stateNext = ACK;
                    readLoad  = !grantWrite;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            ACK: begin
                wMemAck   = grantWrite;
                rMemAck   = !grantWrite;
                memWrite  = grantWrite;
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            grantWrite     <= 1'b0;
            lastGrantWrite <= 1'b0;
            idx            <= '0;
        end else begin
            state          <= stateNext;
            cnt            <= cntNext;
            grantWrite     <= grantWriteNext;
            lastGrantWrite <= lastGrantWriteNext;
            idx            <= idxNext;
        end
    end

    // The write lands on the edge that leaves ACK. Any later read is granted
    // no earlier than the following IDLE cycle and reads the array on the
    // edge into its own ACK, so no forwarding path is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rDataMem <= '0;
            for (int i = 0; i < MEM_LINES; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (memWrite) begin
                mem[idx] <= wDataMem;
            end
            if (readLoad) begin
                rDataMem <= mem[idx];
            end
        end
    end

endmodule
